// File: rtl/sram_async_ctrl_if.sv
// Request/response channel between the on-board bus fabric and sram_async_ctrl.
// The master side issues requests; the slave side (the controller) answers them.
interface sram_async_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_be;
    logic                rsp_valid;
    logic                rsp_we;
    logic [DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/sram_async_ctrl.sv
// Turns a valid/ready request stream into registered, glitch-free asynchronous
// SRAM strobe sequences with cycle-counted read, write-pulse and turnaround timing.
module sram_async_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 18,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_async_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [DATA_W-1:0]   sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [DATA_W/8-1:0] sram_be_n
);
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? (TURN - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("sram_async_ctrl: DATA_W must be a multiple of 8");
    end
    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("sram_async_ctrl: RD_WAIT must be at least 1");
    end
    if (WR_WAIT < 1) begin : g_bad_wr_wait
        $error("sram_async_ctrl: WR_WAIT must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR_SU = 3'd2,
        ST_WR_PW = 3'd3,
        ST_WR_HD = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    // With no turnaround configured an access drops straight back to IDLE.
    localparam state_t ST_AFTER = (TURN > 0) ? ST_TURN : ST_IDLE;

    state_t          state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [BE_W-1:0] be_r;
    logic            accept_s, rd_done_s, wr_done_s;
    logic            ce_n_s, oe_n_s, we_n_s, dq_oe_s;
    logic [BE_W-1:0] be_n_s, wr_be_n_s;

    assign bus.req_ready = (state_r == ST_IDLE);
    assign accept_s      = bus.req_valid && (state_r == ST_IDLE);
    // Lane enables come straight from the request on the accept edge, later from the latch.
    assign wr_be_n_s     = (state_r == ST_IDLE) ? ~bus.req_be : ~be_r;

    // Next-state and wait-counter logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rd_done_s = 1'b0;
        wr_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (accept_s) begin
                    state_s = bus.req_we ? ST_WR_SU : ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == RD_LAST) begin
                    rd_done_s = 1'b1;
                    state_s   = ST_AFTER;
                    cnt_s     = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WR_SU: begin
                state_s = ST_WR_PW;
                cnt_s   = CNT_ZERO;
            end
            ST_WR_PW: begin
                if (cnt_r == WR_LAST) begin
                    wr_done_s = 1'b1;
                    state_s   = ST_WR_HD;
                    cnt_s     = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WR_HD: begin
                state_s = ST_AFTER;
                cnt_s   = CNT_ZERO;
            end
            ST_TURN: begin
                if (cnt_r == TURN_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Strobe decode of the upcoming state, registered below so pads never glitch.
    always_comb begin
        ce_n_s  = 1'b1;
        oe_n_s  = 1'b1;
        we_n_s  = 1'b1;
        dq_oe_s = 1'b0;
        be_n_s  = {BE_W{1'b1}};
        case (state_s)
            ST_RD: begin
                ce_n_s = 1'b0;
                oe_n_s = 1'b0;
                be_n_s = {BE_W{1'b0}};
            end
            ST_WR_SU, ST_WR_HD: begin
                ce_n_s  = 1'b0;
                dq_oe_s = 1'b1;
                be_n_s  = wr_be_n_s;
            end
            ST_WR_PW: begin
                ce_n_s  = 1'b0;
                we_n_s  = 1'b0;
                dq_oe_s = 1'b1;
                be_n_s  = wr_be_n_s;
            end
            default: begin
                ce_n_s = 1'b1;
            end
        endcase
    end

    // State, counter, strobe and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= {BE_W{1'b1}};
            sram_dq_oe    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            sram_ce_n     <= ce_n_s;
            sram_oe_n     <= oe_n_s;
            sram_we_n     <= we_n_s;
            sram_be_n     <= be_n_s;
            sram_dq_oe    <= dq_oe_s;
            bus.rsp_valid <= rd_done_s | wr_done_s;
            bus.rsp_we    <= wr_done_s;
            if (rd_done_s) begin
                bus.rsp_rdata <= sram_dq_i;
            end else begin
                bus.rsp_rdata <= bus.rsp_rdata;
            end
        end
    end

    // Request latch: address and data stay stable on the pins for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a    <= {ADDR_W{1'b0}};
            sram_dq_o <= {DATA_W{1'b0}};
            be_r      <= {BE_W{1'b0}};
        end else if (accept_s) begin
            sram_a    <= bus.req_addr;
            sram_dq_o <= bus.req_wdata;
            be_r      <= bus.req_be;
        end else begin
            sram_a    <= sram_a;
            sram_dq_o <= sram_dq_o;
            be_r      <= be_r;
        end
    end
endmodule

// File: doc/sram_async_ctrl.md
Name: sram_async_ctrl

Overview:
- Synchronous controller that turns a single-clock valid/ready request stream into asynchronous SRAM strobe sequences.
- Target parts are the IS61LV-class parts (x8, x16, or wider with per-byte lane enables).
- Read, write-pulse and bus-turnaround timing are set in clock cycles by parameters.
- Sits between the on-board bus fabric and the external SRAM pads. DQ is split into in/out/oe; the pad tristate lives at top level.

Parameters:
DATA_W   16   SRAM data width; multiple of 8
ADDR_W   18   SRAM word-address width
BE_W     DATA_W/8   byte-lane count (derived)
RD_WAIT  2    cycles CE_n/OE_n held low before sampling read data; >=1
WR_WAIT  2    cycles WE_n held low; >=1
TURN     1    idle cycles (CE_n high, DQ released) after every access; >=0

Ports:
clk          in   1        system clock
rst_n        in   1        reset
req_valid    in   1        request present
req_ready    out  1        controller accepts request
req_we       in   1        1=write, 0=read
req_addr     in   ADDR_W   word address
req_wdata    in   DATA_W   write data
req_be       in   BE_W     write byte enables, active high
rsp_valid    out  1        one-cycle completion pulse (read data valid / write done)
rsp_we       out  1        type of completing access
rsp_rdata    out  DATA_W   read data
sram_a       out  ADDR_W   SRAM address
sram_dq_o    out  DATA_W   SRAM write data
sram_dq_oe   out  1        pad output enable
sram_dq_i    in   DATA_W   SRAM read data
sram_ce_n    out  1        chip enable
sram_oe_n    out  1        output enable
sram_we_n    out  1        write enable
sram_be_n    out  BE_W     byte-lane enables (LB_/UB_ ...)

Interface decision: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.

Behaviour:
- All sram_* outputs, rsp_valid, rsp_we and rsp_rdata are registered (glitch-free strobes). req_ready = (state==IDLE), combinational.
- Reset values: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=all 1, sram_dq_oe=0, sram_a=0, sram_dq_o=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, state=IDLE, counter=0.
- Requests presented while rst_n=0 are ignored.
- Accept: req_valid&&req_ready at cycle 0. Address, data, be and we are latched; nothing is sampled from req_* afterwards.
- States: IDLE, RD, WR_SU, WR_PW, WR_HD, TURN.
- Read path:
  - IDLE->RD: cycles 1..RD_WAIT drive ce_n=0, oe_n=0, be_n=0 (all lanes), dq_oe=0.
  - sram_dq_i is sampled at the end of the last RD cycle.
  - At cycle RD_WAIT+1: rsp_valid=1, rsp_we=0, rsp_rdata=sample. Strobes return high.
  - Next state is TURN, or IDLE if TURN=0.
- Write path:
  - WR_SU, cycle 1: ce_n=0, we_n=1, a, dq_o, be_n=~be, dq_oe=1 (address/data setup).
  - WR_PW, cycles 2..WR_WAIT+1: we_n=0.
  - WR_HD, cycle WR_WAIT+2: we_n=1, ce_n=0, data still driven (hold); rsp_valid=1, rsp_we=1.
  - Next state is TURN, or IDLE if TURN=0.
- TURN: TURN cycles with ce_n=oe_n=we_n=1, be_n=all 1, dq_oe=0. Then IDLE.
- Latencies:
  - Read: response at RD_WAIT+1; next accept at RD_WAIT+1+TURN.
  - Write: ack at WR_WAIT+2; next accept at WR_WAIT+3+TURN.
- Write with req_be=0: full sequence runs with all be_n=1; SRAM contents are unchanged; ack is still issued.
- sram_a and sram_dq_o are held stable from the setup cycle through hold. They are not required to return to 0 after an access.
- rsp_rdata holds its last value between reads. Write completions do not modify it.
- Counter width is clog2(max(RD_WAIT,WR_WAIT,TURN)+1).
- Illegal parameters (DATA_W%8!=0, RD_WAIT<1, WR_WAIT<1): $error at elaboration.
- Reset mid-operation: rst_n low immediately forces all strobes high and dq_oe=0. The in-flight access is dropped with no rsp_valid. After release, state=IDLE.
- req_valid held high continuously: requests are serviced strictly in order, each spaced by the latencies above. There is no overlap and no lost request.

Test Plan (RD_WAIT=2, WR_WAIT=2, TURN=1, DATA_W=16, with the IS61LV behavioural model at 10 ns clk):
- Write addr 0x12345, data 0xBEEF, be=2'b11 at cycle 0 -> we_n low exactly cycles 2-3; dq_oe 1-4; rsp_valid/rsp_we=1 at cycle 4; req_ready high again at cycle 6.
- Read 0x12345 after the above -> ce_n/oe_n low cycles 1-2; rsp_valid=1, rsp_we=0, rsp_rdata=0xBEEF at cycle 3; req_ready at cycle 4.
- Byte lanes: write 0x00AA be=2'b01 to an address holding 0x5555 -> be_n=2'b10 during the access; readback 0x55AA. Write with be=2'b00 -> readback unchanged, ack still seen.
- Back-to-back: req_valid held with the sequence W(0x1,0x1111), R(0x1), W(0x2,0x2222), R(0x2) -> four responses in order; reads return 0x1111 and 0x2222; no two accesses overlap; ce_n high for at least 1 cycle between accesses.
- Reset mid-write: assert rst_n during WR_PW -> we_n/ce_n high and dq_oe=0 in the same cycle; no rsp_valid. After release, first request is accepted at the next cycle.
- TURN=0, RD_WAIT=1 build: back-to-back reads -> one response every 2 cycles with correct data.
